// File: rtl/ttt_move_ctrl.sv
// -----------------------------------------------------------------------------
// ttt_move_ctrl
//
// Purpose:
//   Tic-tac-toe game controller placed directly upstream of nine board cells.
//   It accepts move requests, rejects moves that are out of range or that
//   target an occupied cell, writes legal moves into the addressed cell with
//   a one-cycle set strobe, and then evaluates the board for a win or a draw.
//   The board is cleared on reset and on every new-game request.
//
// Parameters:
//   FIRST_SYMBOL  symbol that moves first after every clear (0 = X, 1 = O)
//   CLEAR_CYCLES  number of cycles o_cell_reset is held during a clear (>= 1)
//
// Ports:
//   i_clk            clock, all state changes on the rising edge
//   i_reset          synchronous, active-high reset
//   i_new_game       request a board clear (sampled every cycle)
//   i_move_valid     move request valid
//   i_move_idx[3:0]  target cell 0..8, row-major
//   o_move_ready     controller can accept a move this cycle
//   o_move_ack       one-cycle pulse: legal move written and evaluated
//   o_move_err       one-cycle pulse: move rejected
//   o_cell_set[8:0]  one-hot set strobe, bit i drives cell i
//   o_cell_reset     clear strobe to all cells
//   o_cell_sym       symbol written by o_cell_set
//   i_cell_valid     occupancy reported by the cells
//   i_cell_symbol    stored symbol reported by the cells
//   o_turn           symbol of the player to move
//   o_move_count     legal moves since the last clear, 0..9
//   o_winner_valid   a line of three is complete
//   o_winner_symbol  symbol of the winning line (0 unless a winner exists)
//   o_draw           nine moves made without a winner
//   o_game_over      o_winner_valid | o_draw
// -----------------------------------------------------------------------------
module ttt_move_ctrl #(
  parameter logic FIRST_SYMBOL = 1'b0,
  parameter int   CLEAR_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_new_game,
  input  logic       i_move_valid,
  input  logic [3:0] i_move_idx,
  output logic       o_move_ready,
  output logic       o_move_ack,
  output logic       o_move_err,
  output logic [8:0] o_cell_set,
  output logic       o_cell_reset,
  output logic       o_cell_sym,
  input  logic [8:0] i_cell_valid,
  input  logic [8:0] i_cell_symbol,
  output logic       o_turn,
  output logic [3:0] o_move_count,
  output logic       o_winner_valid,
  output logic       o_winner_symbol,
  output logic       o_draw,
  output logic       o_game_over
);

  // Clear counter runs 0 .. CLEAR_CYCLES-1.
  localparam int            CW       = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_WRITE,
    S_SETTLE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t        r_state,   w_state_next;
  logic [CW-1:0] r_clr_cnt, w_clr_cnt_next;
  logic [3:0]    r_idx,     w_idx_next;
  logic          r_turn,    w_turn_next;
  logic [3:0]    r_count,   w_count_next;
  logic          r_win_v,   w_win_v_next;
  logic          r_win_s,   w_win_s_next;
  logic          r_draw,    w_draw_next;
  logic          r_err,     w_err_next;

  // ---------------------------------------------------------------------------
  // Line evaluation: each of the eight lines packs its three cell indices as
  // {a, b, c} in a 12-bit word.
  // ---------------------------------------------------------------------------
  function automatic logic [11:0] line_cells(input int k);
    case (k)
      0:       return {4'd0, 4'd1, 4'd2};
      1:       return {4'd3, 4'd4, 4'd5};
      2:       return {4'd6, 4'd7, 4'd8};
      3:       return {4'd0, 4'd3, 4'd6};
      4:       return {4'd1, 4'd4, 4'd7};
      5:       return {4'd2, 4'd5, 4'd8};
      6:       return {4'd0, 4'd4, 4'd8};
      default: return {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  logic [7:0] w_line_win;
  logic [7:0] w_line_sym;
  logic       w_any_win;
  logic       w_win_sym;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      localparam logic [11:0] CELLS = line_cells(gi);
      localparam int A = int'(CELLS[11:8]);
      localparam int B = int'(CELLS[7:4]);
      localparam int C = int'(CELLS[3:0]);
      assign w_line_win[gi] = i_cell_valid[A] & i_cell_valid[B] & i_cell_valid[C] &
                              (i_cell_symbol[A] == i_cell_symbol[B]) &
                              (i_cell_symbol[B] == i_cell_symbol[C]);
      assign w_line_sym[gi] = i_cell_symbol[A];
    end
  endgenerate

  // Only one symbol can complete a line in a legal game; the lowest-numbered
  // winning line is taken as the reported symbol.
  always_comb begin
    w_any_win = |w_line_win;
    w_win_sym = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (w_line_win[k]) begin
        w_win_sym = w_line_sym[k];
      end
    end
  end

  // Illegal when out of range or already occupied. The occupancy lookup is
  // masked for out-of-range indices so it never reads past bit 8.
  logic w_idx_oob;
  logic w_idx_taken;
  logic w_move_bad;

  assign w_idx_oob   = (i_move_idx > 4'd8);
  assign w_idx_taken = !w_idx_oob && i_cell_valid[i_move_idx];
  assign w_move_bad  = w_idx_oob || w_idx_taken;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
      r_idx     <= '0;
      r_turn    <= FIRST_SYMBOL;
      r_count   <= '0;
      r_win_v   <= 1'b0;
      r_win_s   <= 1'b0;
      r_draw    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
      r_idx     <= w_idx_next;
      r_turn    <= w_turn_next;
      r_count   <= w_count_next;
      r_win_v   <= w_win_v_next;
      r_win_s   <= w_win_s_next;
      r_draw    <= w_draw_next;
      r_err     <= w_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    w_idx_next     = r_idx;
    w_turn_next    = r_turn;
    w_count_next   = r_count;
    w_win_v_next   = r_win_v;
    w_win_s_next   = r_win_s;
    w_draw_next    = r_draw;
    w_err_next     = 1'b0;

    if (i_new_game) begin
      // Abort whatever is in flight; leaving WRITE drops cell_set next cycle.
      w_state_next   = S_CLEAR;
      w_clr_cnt_next = '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          w_turn_next  = FIRST_SYMBOL;
          w_count_next = '0;
          w_win_v_next = 1'b0;
          w_win_s_next = 1'b0;
          w_draw_next  = 1'b0;
          if (r_clr_cnt == CLR_LAST) begin
            w_clr_cnt_next = '0;
            w_state_next   = S_IDLE;
          end else begin
            w_clr_cnt_next = r_clr_cnt + 1'b1;
          end
        end

        S_IDLE: begin
          if (i_move_valid) begin
            if (w_move_bad) begin
              w_err_next = 1'b1;
            end else begin
              w_idx_next   = i_move_idx;
              w_state_next = S_WRITE;
            end
          end
        end

        S_WRITE: begin
          w_count_next = (r_count == 4'd9) ? 4'd9 : r_count + 4'd1;
          w_state_next = S_SETTLE;
        end

        // Give the cells one cycle to present the newly written value.
        S_SETTLE: begin
          w_state_next = S_EVAL;
        end

        S_EVAL: begin
          if (w_any_win) begin
            w_win_v_next = 1'b1;
            w_win_s_next = w_win_sym;
            w_state_next = S_DONE;
          end else if (r_count == 4'd9) begin
            w_draw_next  = 1'b1;
            w_state_next = S_DONE;
          end else begin
            w_turn_next  = ~r_turn;
            w_state_next = S_IDLE;
          end
        end

        S_DONE: begin
          w_state_next = S_DONE;
        end

        default: begin
          w_state_next   = S_CLEAR;
          w_clr_cnt_next = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from registered state
  // ---------------------------------------------------------------------------
  assign o_move_ready    = (r_state == S_IDLE);
  assign o_move_ack      = (r_state == S_EVAL);
  assign o_move_err      = r_err;
  assign o_cell_set      = (r_state == S_WRITE) ? (9'(1) << r_idx) : 9'd0;
  assign o_cell_reset    = (r_state == S_CLEAR);
  assign o_cell_sym      = r_turn;
  assign o_turn          = r_turn;
  assign o_move_count    = r_count;
  assign o_winner_valid  = r_win_v;
  assign o_winner_symbol = r_win_s;
  assign o_draw          = r_draw;
  assign o_game_over     = r_win_v | r_draw;

endmodule

// File: tb/tb_ttt_move_ctrl.sv
module tb_ttt_move_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_idx;
  logic       move_ready;
  logic       move_ack;
  logic       move_err;
  logic [8:0] cell_set;
  logic       cell_reset;
  logic       cell_sym;
  logic [8:0] cell_valid;
  logic [8:0] cell_symbol;
  logic       turn;
  logic [3:0] move_count;
  logic       winner_valid;
  logic       winner_symbol;
  logic       draw;
  logic       game_over;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  ttt_move_ctrl #(
    .FIRST_SYMBOL(1'b0),
    .CLEAR_CYCLES(2)
  ) u_dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_new_game     (new_game),
    .i_move_valid   (move_valid),
    .i_move_idx     (move_idx),
    .o_move_ready   (move_ready),
    .o_move_ack     (move_ack),
    .o_move_err     (move_err),
    .o_cell_set     (cell_set),
    .o_cell_reset   (cell_reset),
    .o_cell_sym     (cell_sym),
    .i_cell_valid   (cell_valid),
    .i_cell_symbol  (cell_symbol),
    .o_turn         (turn),
    .o_move_count   (move_count),
    .o_winner_valid (winner_valid),
    .o_winner_symbol(winner_symbol),
    .o_draw         (draw),
    .o_game_over    (game_over)
  );

  // Nine board cells: clear on cell_reset, capture symbol on their set bit.
  always @(posedge clk) begin
    if (cell_reset) begin
      cell_valid  <= '0;
      cell_symbol <= '0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (cell_set[i]) begin
          cell_valid[i]  <= 1'b1;
          cell_symbol[i] <= cell_sym;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Structural properties checked every cycle once out of reset.
  always @(negedge clk) begin
    if (mon_en) begin
      check("set_rst_excl", 32'((cell_set != 9'd0) && cell_reset), 32'd0);
      check("set_onehot", 32'($countones(cell_set) <= 1), 32'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: board of 0 = empty, 1 = X, 2 = O
  // ---------------------------------------------------------------------------
  int board [9];
  int m_turn, m_count, m_wsym;
  bit m_over, m_win, m_draw;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic model_clear();
    foreach (board[i]) board[i] = 0;
    m_turn = 0; m_count = 0; m_wsym = 0;
    m_over = 0; m_win = 0; m_draw = 0;
  endtask

  task automatic model_apply(input int idx);
    board[idx] = m_turn + 1;
    m_count++;
    for (int l = 0; l < 8; l++) begin
      if (board[lines[l][0]] != 0 &&
          board[lines[l][0]] == board[lines[l][1]] &&
          board[lines[l][1]] == board[lines[l][2]]) begin
        m_win  = 1;
        m_wsym = board[lines[l][0]] - 1;
      end
    end
    if (m_win)              m_over = 1;
    else if (m_count == 9) begin m_draw = 1; m_over = 1; end
    else                    m_turn = 1 - m_turn;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_ready"},  32'(move_ready),    32'(!m_over));
    check({tag, "_turn"},   32'(turn),          32'(m_turn));
    check({tag, "_count"},  32'(move_count),    32'(m_count));
    check({tag, "_winv"},   32'(winner_valid),  32'(m_win));
    check({tag, "_wsym"},   32'(winner_symbol), m_win ? 32'(m_wsym) : 32'd0);
    check({tag, "_draw"},   32'(draw),          32'(m_draw));
    check({tag, "_over"},   32'(game_over),     32'(m_over));
    check({tag, "_cellrst"}, 32'(cell_reset),   32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called from IDLE or DONE, one time unit after a rising edge.
  task automatic start_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("clr1_rst",   32'(cell_reset), 32'd1);
    check("clr1_ready", 32'(move_ready), 32'd0);
    check("clr1_set",   32'(cell_set),   32'd0);
    tick();
    check("clr2_rst",   32'(cell_reset), 32'd1);
    tick();
    model_clear();
    check_status("clear");
    $display("new_game -> board cleared");
  endtask

  task automatic play(input int idx);
    bit legal;
    if (m_over) begin
      check("done_ready", 32'(move_ready), 32'd0);
      move_valid = 1'b1;
      move_idx   = 4'(idx);
      for (int c = 0; c < 4; c++) begin
        tick();
        move_valid = 1'b0;
        check("done_err", 32'(move_err), 32'd0);
        check("done_set", 32'(cell_set), 32'd0);
        check("done_ack", 32'(move_ack), 32'd0);
      end
      check_status("done_hold");
      $display("move idx=%0d ignored (game over)", idx);
      return;
    end
    check("ready", 32'(move_ready), 32'd1);
    legal = (idx <= 8) ? (board[idx] == 0) : 1'b0;
    move_valid = 1'b1;
    move_idx   = 4'(idx);
    tick();
    move_valid = 1'b0;
    if (!legal) begin
      check("err_pulse", 32'(move_err), 32'd1);
      check("err_noset", 32'(cell_set), 32'd0);
      tick();
      check("err_clear", 32'(move_err), 32'd0);
      check("err_noack", 32'(move_ack), 32'd0);
      check_status("err_hold");
      $display("move idx=%0d rejected: turn=%0d count=%0d", idx, m_turn, m_count);
      return;
    end
    check("set",       32'(cell_set), 32'(9'(1) << idx));
    check("sym",       32'(cell_sym), 32'(m_turn));
    check("err_legal", 32'(move_err), 32'd0);
    tick();
    check("settle_set",   32'(cell_set),   32'd0);
    check("settle_count", 32'(move_count), 32'(m_count + 1));
    check("settle_ack",   32'(move_ack),   32'd0);
    tick();
    check("ack",        32'(move_ack),   32'd1);
    check("eval_ready", 32'(move_ready), 32'd0);
    model_apply(idx);
    tick();
    check("ack_drop", 32'(move_ack), 32'd0);
    check_status("post_move");
    $display("move idx=%0d accepted: count=%0d win=%0d draw=%0d next_turn=%0d",
             idx, m_count, m_win, m_draw, m_turn);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq4 [5] = '{0, 3, 1, 4, 2};
    int seq5 [9] = '{0, 1, 2, 4, 3, 6, 7, 8, 5};

    reset      = 1'b1;
    new_game   = 1'b0;
    move_valid = 1'b0;
    move_idx   = '0;
    model_clear();
    tick();
    reset = 1'b0;
    mon_en = 1'b1;

    // Reset state and clear window
    check("rst_cellrst", 32'(cell_reset),   32'd1);
    check("rst_ready",   32'(move_ready),   32'd0);
    check("rst_turn",    32'(turn),         32'd0);
    check("rst_count",   32'(move_count),   32'd0);
    check("rst_over",    32'(game_over),    32'd0);
    check("rst_ack",     32'(move_ack),     32'd0);
    check("rst_err",     32'(move_err),     32'd0);
    check("rst_set",     32'(cell_set),     32'd0);
    tick();
    check("rst2_cellrst", 32'(cell_reset), 32'd1);
    check("rst2_ready",   32'(move_ready), 32'd0);
    tick();
    check_status("rst3");
    $display("reset -> idle after clear");

    // Centre move, repeated move, out-of-range move
    play(4);
    play(4);
    play(9);

    // X wins on the top row
    start_new_game();
    foreach (seq4[i]) play(seq4[i]);
    check("t4_winv", 32'(winner_valid),  32'd1);
    check("t4_wsym", 32'(winner_symbol), 32'd0);
    play(5);

    // Full board, no winner
    start_new_game();
    foreach (seq5[i]) play(seq5[i]);
    check("t5_draw",  32'(draw),         32'd1);
    check("t5_winv",  32'(winner_valid), 32'd0);
    check("t5_count", 32'(move_count),   32'd9);
    play(0);

    // new_game while a move is being written
    start_new_game();
    play(0);
    move_valid = 1'b1;
    move_idx   = 4'd5;
    tick();
    move_valid = 1'b0;
    check("abort_set", 32'(cell_set), 32'h020);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("abort_setdrop", 32'(cell_set),   32'd0);
    check("abort_cellrst", 32'(cell_reset), 32'd1);
    tick();
    check("abort_cellrst2", 32'(cell_reset), 32'd1);
    tick();
    model_clear();
    check_status("abort");
    $display("new_game during write -> aborted and cleared");

    // Randomized games, including out-of-range and occupied targets
    for (int g = 0; g < 30; g++) begin
      start_new_game();
      for (int a = 0; a < 20; a++) begin
        if (m_over) begin
          play(int'($urandom_range(0, 10)));
          break;
        end
        play(int'($urandom_range(0, 10)));
        if ($urandom_range(0, 24) == 0) break;
      end
    end

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
